// File: rtl/config_pkg.sv
// Shared accelerator configuration record; the energy monitor only reads DATA_WIDTH.
package config_pkg;

    typedef struct packed {
        int unsigned DATA_WIDTH;
    } config_t;

    localparam config_t DEFAULT_CFG = '{DATA_WIDTH: 16};

endpackage

// File: rtl/energy_pkg.sv
// Types and saturating arithmetic shared by the transfer-energy monitor.
package energy_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        REPORT
    } state_e;

    // Accumulators up to 64 bits wide share these helpers; callers zero-extend.
    localparam int SAT_W = 64;

    function automatic logic [SAT_W:0] wide_sum(input logic [SAT_W-1:0] a,
                                                input logic [SAT_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic sat_overflow(input logic [SAT_W-1:0] acc,
                                          input logic [SAT_W-1:0] inc,
                                          input logic [SAT_W-1:0] max_val);
        return wide_sum(acc, inc) > {1'b0, max_val};
    endfunction

    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] acc,
                                                 input logic [SAT_W-1:0] inc,
                                                 input logic [SAT_W-1:0] max_val);
        return sat_overflow(acc, inc, max_val) ? max_val : SAT_W'(wide_sum(acc, inc));
    endfunction

endpackage

// File: rtl/sat_accum.sv
// Unsigned accumulator that clamps at all-ones and keeps a sticky overflow flag.
module sat_accum
    import energy_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] inc,
    output logic [WIDTH-1:0] value,
    output logic             sat
);

    localparam logic [SAT_W-1:0] MAX_VAL = SAT_W'({WIDTH{1'b1}});

    logic [WIDTH-1:0] value_q, value_d;
    logic             sat_q, sat_d;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        value_d = value_q;
        sat_d   = sat_q;
        if (clr) begin
            value_d = '0;
            sat_d   = 1'b0;
        end else if (en) begin
            value_d = WIDTH'(sat_add(SAT_W'(value_q), SAT_W'(inc), MAX_VAL));
            sat_d   = sat_q | sat_overflow(SAT_W'(value_q), SAT_W'(inc), MAX_VAL);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            value_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its inputs.
            value_q <= value_d;
            sat_q   <= sat_d;
        end
    end

    assign value = value_q;
    assign sat   = sat_q;

endmodule

// File: rtl/xfer_energy_monitor.sv
// Counts charged transfers on NB_PORTS valid/ready streams over a start/stop window
// and offers energy, per-port counts and window length through a report handshake.
module xfer_energy_monitor
    import energy_pkg::*;
#(
    parameter config_pkg::config_t cfg                    = config_pkg::DEFAULT_CFG,
    parameter int                  NB_PORTS               = 3,
    parameter int                  PORT_WEIGHT [NB_PORTS] = '{default: 1},
    parameter int                  CNT_WIDTH              = 32,
    parameter int                  ENERGY_WIDTH           = 48
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          clear,
    input  logic [NB_PORTS-1:0]           port_valid,
    input  logic [NB_PORTS-1:0]           port_ready,
    input  logic [NB_PORTS-1:0]           port_zero,
    output logic                          running,
    output logic                          report_valid,
    input  logic                          report_ready,
    output logic [ENERGY_WIDTH-1:0]       energy,
    output logic [NB_PORTS*CNT_WIDTH-1:0] xfer_count,
    output logic [CNT_WIDTH-1:0]          cycles,
    output logic                          saturated
);

    state_e                  state_q, state_d;
    logic                    acc_clr;
    logic                    acc_en;
    logic [NB_PORTS-1:0]     charged;
    logic [ENERGY_WIDTH-1:0] energy_inc;
    logic [NB_PORTS+1:0]     sat_flags;

    assign charged = port_valid & port_ready & ~port_zero;
    assign acc_en  = (state_q == COUNT);

    // Accumulators are zeroed on the edge that opens a window, so a back-to-back
    // start from REPORT behaves exactly like a start from IDLE.
    always_comb begin
        state_d = state_q;
        acc_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COUNT;
                    acc_clr = 1'b1;
                end
            end
            COUNT: begin
                if (stop) state_d = REPORT;
            end
            REPORT: begin
                if (report_ready) begin
                    state_d = start ? COUNT : IDLE;
                    acc_clr = start;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
            acc_clr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        energy_inc = '0;
        for (int p = 0; p < NB_PORTS; p++) begin
            if (charged[p]) begin
                energy_inc = energy_inc + ENERGY_WIDTH'(PORT_WEIGHT[p] * cfg.DATA_WIDTH);
            end
        end
    end

    for (genvar p = 0; p < NB_PORTS; p++) begin : g_port
        sat_accum #(.WIDTH(CNT_WIDTH)) u_xfer_cnt (
            .clk    (clk),
            .arst_n (arst_n),
            .clr    (acc_clr),
            .en     (acc_en & charged[p]),
            .inc    (CNT_WIDTH'(1)),
            .value  (xfer_count[p*CNT_WIDTH +: CNT_WIDTH]),
            .sat    (sat_flags[p])
        );
    end

    sat_accum #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .clr    (acc_clr),
        .en     (acc_en),
        .inc    (CNT_WIDTH'(1)),
        .value  (cycles),
        .sat    (sat_flags[NB_PORTS])
    );

    sat_accum #(.WIDTH(ENERGY_WIDTH)) u_energy_acc (
        .clk    (clk),
        .arst_n (arst_n),
        .clr    (acc_clr),
        .en     (acc_en),
        .inc    (energy_inc),
        .value  (energy),
        .sat    (sat_flags[NB_PORTS+1])
    );

    assign running      = (state_q == COUNT);
    assign report_valid = (state_q == REPORT);
    assign saturated    = |sat_flags;

endmodule
